// File: rtl/dram_cmd_sched_if.sv
// User command port of dram_cmd_sched: a valid/ready handshake carrying one DDR3 command.
interface dram_cmd_sched_if;
   logic        valid;
   logic        ready;
   logic [2:0]  cmd;
   logic [2:0]  ba;
   logic [15:0] addr;

   modport master (output valid, output cmd, output ba, output addr, input ready);
   modport slave  (input valid, input cmd, input ba, input addr, output ready);
endinterface

// File: rtl/dram_cmd_sched.sv
// DDR3 command sequencer: JEDEC power-up, user command forwarding, and periodic
// precharge-all + auto-refresh preemption, all on divclk.
module dram_cmd_sched #(
   parameter int unsigned T_RSTL = 20000,
   parameter int unsigned T_CKE  = 50000,
   parameter int unsigned T_MRD  = 4,
   parameter int unsigned T_ZQ   = 512,
   parameter int unsigned T_RP   = 6,
   parameter int unsigned T_RFC  = 110,
   parameter int unsigned T_REFI = 3900,
   parameter logic [15:0] MR0    = 16'h0,
   parameter logic [15:0] MR1    = 16'h0,
   parameter logic [15:0] MR2    = 16'h0,
   parameter logic [15:0] MR3    = 16'h0
) (
   input  logic             divclk,
   input  logic             reset,
   dram_cmd_sched_if.slave  req,
   output logic             dram_reset_n,
   output logic             dram_cke,
   output logic             dram_cs_n,
   output logic             dram_ras_n,
   output logic             dram_cas_n,
   output logic             dram_we_n,
   output logic [2:0]       dram_ba,
   output logic [15:0]      dram_addr,
   output logic             init_done,
   output logic             ref_active,
   output logic             ref_overrun
);

   localparam int unsigned MAX_AB = (T_RSTL > T_CKE) ? T_RSTL : T_CKE;
   localparam int unsigned MAX_CD = (T_ZQ > T_RFC) ? T_ZQ : T_RFC;
   localparam int unsigned MAX_EF = (T_MRD > T_RP) ? T_MRD : T_RP;
   localparam int unsigned MAX_G  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_T  = (MAX_G > MAX_EF) ? MAX_G : MAX_EF;
   localparam int unsigned CW     = $clog2(MAX_T + 1);
   localparam int unsigned RW     = $clog2(T_REFI + 1);

   localparam logic [2:0]  CMD_MRS = 3'b000;
   localparam logic [2:0]  CMD_REF = 3'b001;
   localparam logic [2:0]  CMD_PRE = 3'b010;
   localparam logic [2:0]  CMD_ZQ  = 3'b110;
   localparam logic [2:0]  CMD_NOP = 3'b111;
   localparam logic [15:0] A10     = 16'h0400;

   typedef enum logic [3:0] {
      S_RST_HOLD, S_CKE_WAIT, S_MRS2, S_MRS3, S_MRS1, S_MRS0,
      S_ZQCL, S_IDLE, S_REF_ARM, S_PREA, S_REF
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [RW-1:0] refi_cnt;
   logic          ref_pending;
   logic          ref_issue_c;

   // REF goes out on the edge the precharge wait expires; that edge retires the pending refresh.
   assign ref_issue_c = (state == S_PREA) && (cnt == '0);

   always_ff @(posedge divclk or posedge reset) begin
      if (reset) begin
         state        <= S_RST_HOLD;
         cnt          <= CW'(T_RSTL);
         refi_cnt     <= '0;
         ref_pending  <= 1'b0;
         dram_reset_n <= 1'b0;
         dram_cke     <= 1'b0;
         dram_cs_n    <= 1'b1;
         {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_NOP;
         dram_ba      <= '0;
         dram_addr    <= '0;
         req.ready    <= 1'b0;
         init_done    <= 1'b0;
         ref_active   <= 1'b0;
         ref_overrun  <= 1'b0;
      end else begin
         // NOP unless a state below issues a command; ba/addr hold.
         dram_cs_n <= 1'b1;
         {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_NOP;
         if (cnt != '0) cnt <= cnt - CW'(1);

         case (state)
            S_RST_HOLD: if (cnt == '0) begin
               state        <= S_CKE_WAIT;
               cnt          <= CW'(T_CKE - 1);
               dram_reset_n <= 1'b1;
            end
            S_CKE_WAIT: if (cnt == '0) begin
               state     <= S_MRS2;
               cnt       <= CW'(T_MRD);
               dram_cke  <= 1'b1;
               dram_cs_n <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_MRS;
               dram_ba   <= 3'd2;
               dram_addr <= MR2;
            end
            S_MRS2: if (cnt == '0) begin
               state     <= S_MRS3;
               cnt       <= CW'(T_MRD);
               dram_cs_n <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_MRS;
               dram_ba   <= 3'd3;
               dram_addr <= MR3;
            end
            S_MRS3: if (cnt == '0) begin
               state     <= S_MRS1;
               cnt       <= CW'(T_MRD);
               dram_cs_n <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_MRS;
               dram_ba   <= 3'd1;
               dram_addr <= MR1;
            end
            S_MRS1: if (cnt == '0) begin
               state     <= S_MRS0;
               cnt       <= CW'(T_MRD);
               dram_cs_n <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_MRS;
               dram_ba   <= 3'd0;
               dram_addr <= MR0;
            end
            S_MRS0: if (cnt == '0) begin
               state     <= S_ZQCL;
               cnt       <= CW'(T_ZQ);
               dram_cs_n <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_ZQ;
               dram_ba   <= 3'd0;
               dram_addr <= A10;
            end
            S_ZQCL: if (cnt == '0) begin
               state     <= S_IDLE;
               init_done <= 1'b1;
               req.ready <= 1'b1;
               refi_cnt  <= RW'(T_REFI - 1);
            end
            S_IDLE: begin
               if (req.ready && req.valid) begin
                  dram_cs_n <= 1'b0;
                  {dram_ras_n, dram_cas_n, dram_we_n} <= req.cmd;
                  dram_ba   <= req.ba;
                  dram_addr <= req.addr;
               end
               if (ref_pending) begin
                  state     <= S_REF_ARM;
                  req.ready <= 1'b0;
               end else begin
                  req.ready <= 1'b1;
               end
            end
            S_REF_ARM: begin
               state      <= S_PREA;
               cnt        <= CW'(T_RP);
               ref_active <= 1'b1;
               dram_cs_n  <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_PRE;
               dram_addr  <= A10;
            end
            S_PREA: if (cnt == '0) begin
               state       <= S_REF;
               cnt         <= CW'(T_RFC);
               ref_pending <= 1'b0;
               dram_cs_n   <= 1'b0;
               {dram_ras_n, dram_cas_n, dram_we_n} <= CMD_REF;
            end
            S_REF: if (cnt == '0) begin
               state      <= S_IDLE;
               ref_active <= 1'b0;
               req.ready  <= !ref_pending;
            end
            default: state <= S_RST_HOLD;
         endcase

         // Free-running refresh interval; a new expiry overrides a same-edge clear.
         if (init_done) begin
            if (refi_cnt == '0) begin
               refi_cnt    <= RW'(T_REFI - 1);
               ref_pending <= 1'b1;
               if (ref_pending && !ref_issue_c) ref_overrun <= 1'b1;
            end else begin
               refi_cnt <= refi_cnt - RW'(1);
            end
         end
      end
   end

endmodule

// File: doc/dram_cmd_sched.md
# dram_cmd_sched

DDR3 command sequencer and refresh scheduler sitting between the memory controller's user command port and `dram_phy`'s command pins, in the `divclk` domain.

- Runs the JEDEC power-up sequence: reset_n hold, CKE wait, MR2/MR3/MR1/MR0 loads, ZQCL.
- Then forwards user commands over a valid/ready handshake.
- Periodically preempts user traffic to issue precharge-all plus auto-refresh.

## Interface
Parameters:
- T_RSTL, 20000: cycles reset_n held low after reset release.
- T_CKE, 50000: cycles reset_n high, CKE low, before the first command.
- T_MRD, 4: idle cycles after each MRS.
- T_ZQ, 512: idle cycles after ZQCL.
- T_RP, 6: idle cycles after precharge-all.
- T_RFC, 110: idle cycles after REF.
- T_REFI, 3900: refresh interval in cycles.
- MR0, MR1, MR2, MR3, 16'h0: mode register address values.

Ports:
- divclk in 1: command clock; all logic is on its rising edge.
- reset in 1: asynchronous, active-high.
- req_valid in 1: user command valid.
- req_ready out 1: block accepts a user command this cycle.
- req_cmd in 3: {ras_n,cas_n,we_n}.
- req_ba in 3: bank address.
- req_addr in 16: row/column address.
- dram_reset_n out 1: to phy reset_n.
- dram_cke out 1: to phy cke (both ranks driven identically by phy).
- dram_cs_n out 1: chip select, active low.
- dram_ras_n, dram_cas_n, dram_we_n out 1 each.
- dram_ba out 3.
- dram_addr out 16.
- init_done out 1: init sequence complete; sticky until reset.
- ref_active out 1: high from PREA issue until end of the tRFC wait.
- ref_overrun out 1: sticky error; a refresh interval expired while the previous refresh was still pending.

## Operation
- All outputs are registered.
- Reset values:
  - dram_reset_n=0, dram_cke=0, dram_cs_n=1.
  - ras/cas/we_n=1, ba=0, addr=0.
  - req_ready=0, init_done=0, ref_active=0, ref_overrun=0.
- Any cycle without a command drives NOP: cs_n=1, ras/cas/we_n=1. ba/addr hold their last value.
- State machine (one down-counter, loaded on entry to each state; exits when it reaches 0):
  - RST_HOLD, T_RSTL cycles: reset_n=0, cke=0.
  - CKE_WAIT, T_CKE cycles: reset_n=1, cke=0.
  - MRS2, MRS3, MRS1, MRS0, each a 1-cycle command then T_MRD NOP cycles.
    - Command: cs_n=0, cmd=000, ba = 2/3/1/0, addr = MR2/MR3/MR1/MR0.
    - cke=1 from entry to MRS2 onward.
  - ZQCL: 1 cycle with cmd=110, addr[10]=1, other address bits 0, ba=0; then T_ZQ NOPs.
  - IDLE: init_done=1.
    - req_ready=1 unless a refresh is pending.
    - On req_valid&&req_ready, the command is driven the next cycle: cs_n=0, cmd/ba/addr from the request.
  - PREA: cmd=010, addr[10]=1, then T_RP NOPs.
  - REF: cmd=001, then T_RFC NOPs, then back to IDLE.
- Refresh timer:
  - Starts counting when init_done rises.
  - Sets ref_pending every T_REFI cycles, free-running and not restarted by refreshes.
  - In IDLE with ref_pending, the FSM goes to PREA the next cycle and req_ready is 0 that cycle.
  - ref_pending clears when REF is issued.
  - If the timer expires while ref_pending=1, ref_overrun is set. Pending does not accumulate beyond one.
- The block issues no user commands during the init, PREA, or REF windows.
- Bank/timing legality of user commands (tRCD, tRAS, etc.) is the requester's responsibility. The block only guarantees banks are closed before REF.

## Timing
- Reset release is cycle 0 (first divclk rising edge with reset low).
- dram_reset_n rises at cycle T_RSTL.
- MRS2 is issued at T_RSTL+T_CKE. Each subsequent init command follows its predecessor by T_MRD+1 cycles. ZQCL is issued at T_RSTL+T_CKE+4(T_MRD+1).
- init_done rises at T_RSTL+T_CKE+4(T_MRD+1)+T_ZQ+1.
- User latency: command accepted at cycle n appears on the dram_* outputs at n+1, with cs_n low for exactly one cycle.
- Back-to-back accepts issue back-to-back commands.
- Refresh:
  - req_ready falls in the cycle after ref_pending sets.
  - PREA is issued 1 cycle after that.
  - REF is issued T_RP+1 cycles after PREA.
  - IDLE (req_ready=1) returns T_RFC+1 cycles after REF.
- A request arriving with req_valid in the same cycle ref_pending sets is accepted, because req_ready was still 1. PREA follows that command by one cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The sequence restarts from RST_HOLD, and the refresh timer and sticky flags clear.

## Test plan
Parameters: T_RSTL=8, T_CKE=10, T_MRD=4, T_ZQ=16, T_RP=3, T_RFC=12, T_REFI=100, MR0=16'h0520, MR1=16'h0044, MR2=16'h0008, MR3=0.
- Init sequence: release reset -> reset_n rises at cycle 8; MRS with ba=2,3,1,0 at cycles 18, 23, 28, 33; ZQCL at 38 with addr=16'h0400; init_done rises at 55.
- Single user command: req ACT (cmd=011, ba=5, addr=16'h1234) with valid in IDLE -> the same values appear on the outputs with cs_n=0 for exactly one cycle, one cycle later.
- Streaming: valid held for 10 cycles with incrementing addr -> 10 consecutive commands, no gaps, order preserved.
- Refresh preemption: valid held continuously -> every 100 cycles, req_ready drops, then PREA, REF 4 cycles later, ready returns 13 cycles after REF; no user command is issued inside the window.
- Overrun: set T_REFI=10 (shorter than the refresh window) -> ref_overrun goes high and stays high.
- Mid-operation reset: assert reset during the MRS1 wait, then during REF -> outputs return to reset values immediately; the init timing from the first scenario repeats exactly after release.
